// File: rtl/axi4_addr_decoder_1x2_pkg.sv
// Shared widths, default memory map and FSM encodings for the 1-to-2 AXI4 address decoder.
package axi4_addr_decoder_1x2_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Slave 1 (MMIO) owns the 256 MB window at 0x1000_0000; all else is main memory.
    localparam logic [ADDR_W-1:0] S1_BASE_DEF = 32'h1000_0000;
    localparam logic [ADDR_W-1:0] S1_MASK_DEF = 32'hF000_0000;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FWD  = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

endpackage

// File: rtl/axi4_addr_decoder_1x2_if.sv
// Single-beat AXI4 channel bundle (AW, W, B, AR, R) shared by the interconnect side and both slaves.
interface axi4_addr_decoder_1x2_if;
    import axi4_addr_decoder_1x2_pkg::*;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bvalid, arready, rdata, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bvalid, arready, rdata, rvalid
    );

endinterface

// File: rtl/axi4_addr_decoder_1x2_match.sv
// Combinational base/mask comparator; hit means the address belongs to slave 1.
module axi4_addr_decoder_1x2_match
    import axi4_addr_decoder_1x2_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE = S1_BASE_DEF,
    parameter logic [ADDR_W-1:0] MASK = S1_MASK_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit
);

    assign hit = ((addr & MASK) == BASE);

endmodule

// File: rtl/axi4_addr_decoder_1x2.sv
// Routes single-beat AXI4 reads and writes to main memory (m0) or MMIO (m1); independent
// read and write FSMs, each with one transaction in flight.
module axi4_addr_decoder_1x2
    import axi4_addr_decoder_1x2_pkg::*;
#(
    parameter logic [ADDR_W-1:0] S1_BASE = S1_BASE_DEF,
    parameter logic [ADDR_W-1:0] S1_MASK = S1_MASK_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    axi4_addr_decoder_1x2_if.slave   s_axi,
    axi4_addr_decoder_1x2_if.master  m0_axi,
    axi4_addr_decoder_1x2_if.master  m1_axi
);

    rd_state_t         rd_state;
    logic [ADDR_W-1:0] araddr_q;
    logic              sel_r;
    logic              ar_hit;
    logic              sel_arready;
    logic              sel_rvalid;

    wr_state_t         wr_state;
    logic [ADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              got_aw;
    logic              got_w;
    logic              aw_pend;
    logic              w_pend;
    logic              sel_w;
    logic              aw_hit;
    logic              sel_awready;
    logic              sel_wready;
    logic              sel_bvalid;
    logic              aw_done;
    logic              w_done;
    logic              rd_active;
    logic              wr_active;

    axi4_addr_decoder_1x2_match #(.BASE(S1_BASE), .MASK(S1_MASK)) u_ar_match (
        .addr (s_axi.araddr),
        .hit  (ar_hit)
    );

    axi4_addr_decoder_1x2_match #(.BASE(S1_BASE), .MASK(S1_MASK)) u_aw_match (
        .addr (awaddr_q),
        .hit  (aw_hit)
    );

    assign sel_arready = sel_r ? m1_axi.arready : m0_axi.arready;
    assign sel_rvalid  = sel_r ? m1_axi.rvalid  : m0_axi.rvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= R_IDLE;
            araddr_q <= '0;
            sel_r    <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: if (s_axi.arvalid) begin
                    araddr_q <= s_axi.araddr;
                    sel_r    <= ar_hit;
                    rd_state <= R_ADDR;
                end
                R_ADDR: if (sel_arready) rd_state <= R_DATA;
                R_DATA: if (sel_rvalid && s_axi.rready) rd_state <= R_IDLE;
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // The unselected slave sees all-zero valids, readies and address.
    assign rd_active      = (rd_state != R_IDLE);
    assign s_axi.arready  = (rd_state == R_IDLE);
    assign m0_axi.arvalid = (rd_state == R_ADDR) && !sel_r;
    assign m1_axi.arvalid = (rd_state == R_ADDR) &&  sel_r;
    assign m0_axi.araddr  = (rd_active && !sel_r) ? araddr_q : '0;
    assign m1_axi.araddr  = (rd_active &&  sel_r) ? araddr_q : '0;
    assign m0_axi.rready  = (rd_state == R_DATA) && !sel_r && s_axi.rready;
    assign m1_axi.rready  = (rd_state == R_DATA) &&  sel_r && s_axi.rready;
    assign s_axi.rvalid   = (rd_state == R_DATA) && sel_rvalid;
    assign s_axi.rdata    = (rd_state != R_DATA) ? '0 : (sel_r ? m1_axi.rdata : m0_axi.rdata);

    assign sel_awready = sel_w ? m1_axi.awready : m0_axi.awready;
    assign sel_wready  = sel_w ? m1_axi.wready  : m0_axi.wready;
    assign sel_bvalid  = sel_w ? m1_axi.bvalid  : m0_axi.bvalid;
    assign aw_done     = !aw_pend || sel_awready;
    assign w_done      = !w_pend  || sel_wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= W_IDLE;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            got_aw   <= 1'b0;
            got_w    <= 1'b0;
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            sel_w    <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (s_axi.awvalid && !got_aw) begin
                        awaddr_q <= s_axi.awaddr;
                        got_aw   <= 1'b1;
                    end
                    if (s_axi.wvalid && !got_w) begin
                        wdata_q <= s_axi.wdata;
                        wstrb_q <= s_axi.wstrb;
                        got_w   <= 1'b1;
                    end
                    if (got_aw && got_w) begin
                        sel_w    <= aw_hit;
                        aw_pend  <= 1'b1;
                        w_pend   <= 1'b1;
                        wr_state <= W_FWD;
                    end
                end
                W_FWD: begin
                    if (sel_awready) aw_pend <= 1'b0;
                    if (sel_wready)  w_pend  <= 1'b0;
                    if (aw_done && w_done) wr_state <= W_RESP;
                end
                W_RESP: if (sel_bvalid && s_axi.bready) begin
                    got_aw   <= 1'b0;
                    got_w    <= 1'b0;
                    wr_state <= W_IDLE;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    assign wr_active      = (wr_state != W_IDLE);
    assign s_axi.awready  = (wr_state == W_IDLE) && !got_aw;
    assign s_axi.wready   = (wr_state == W_IDLE) && !got_w;
    assign m0_axi.awvalid = (wr_state == W_FWD) && aw_pend && !sel_w;
    assign m1_axi.awvalid = (wr_state == W_FWD) && aw_pend &&  sel_w;
    assign m0_axi.wvalid  = (wr_state == W_FWD) && w_pend  && !sel_w;
    assign m1_axi.wvalid  = (wr_state == W_FWD) && w_pend  &&  sel_w;
    assign m0_axi.awaddr  = (wr_active && !sel_w) ? awaddr_q : '0;
    assign m1_axi.awaddr  = (wr_active &&  sel_w) ? awaddr_q : '0;
    assign m0_axi.wdata   = (wr_active && !sel_w) ? wdata_q  : '0;
    assign m1_axi.wdata   = (wr_active &&  sel_w) ? wdata_q  : '0;
    assign m0_axi.wstrb   = (wr_active && !sel_w) ? wstrb_q  : '0;
    assign m1_axi.wstrb   = (wr_active &&  sel_w) ? wstrb_q  : '0;
    assign m0_axi.bready  = (wr_state == W_RESP) && !sel_w && s_axi.bready;
    assign m1_axi.bready  = (wr_state == W_RESP) &&  sel_w && s_axi.bready;
    assign s_axi.bvalid   = (wr_state == W_RESP) && sel_bvalid;

endmodule

// File: tb/tb_axi4_addr_decoder_1x2.sv
// Self-checking bench: two behavioural slaves with random readiness, directed scenarios and
// randomized traffic checked against an address-range memory map model.
`timescale 1ns/1ps
module tb_axi4_addr_decoder_1x2;
    import axi4_addr_decoder_1x2_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   chk = 0;
    int   err = 0;
    int   cyc = 0;

    axi4_addr_decoder_1x2_if s_if ();
    axi4_addr_decoder_1x2_if m_if [2] ();

    axi4_addr_decoder_1x2 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_axi  (s_if),
        .m0_axi (m_if[0]),
        .m1_axi (m_if[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory map model: MMIO is the address range [0x1000_0000, 0x2000_0000).
    function automatic int exp_slave(input logic [31:0] a);
        return (a >= 32'h1000_0000 && a < 32'h2000_0000) ? 1 : 0;
    endfunction

    function automatic logic [31:0] slave_data(input int s, input logic [31:0] a);
        if (s == 0 && a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return a ^ ((s == 0) ? 32'h5A5A_0000 : 32'hC3C3_0000);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : slv
        int          lat = 2;
        bit          block_ar = 1'b0;
        int          ar_count = 0;
        int          r_count = 0;
        int          aw_count = 0;
        int          w_count = 0;
        int          b_count = 0;
        int          arv_cyc = -1;
        logic [31:0] last_araddr = '0;
        logic [31:0] last_awaddr = '0;
        logic [31:0] last_wdata = '0;
        logic [3:0]  last_wstrb = '0;

        initial begin : rd_model
            int          phase;
            int          cnt;
            bit          arv_seen;
            logic [31:0] resp;
            phase = 0; cnt = 0; arv_seen = 1'b0; resp = '0;
            m_if[g].arready = 1'b0;
            m_if[g].rvalid  = 1'b0;
            m_if[g].rdata   = '0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    phase = 0; arv_seen = 1'b0;
                    m_if[g].arready = 1'b0;
                    m_if[g].rvalid  = 1'b0;
                end else if (phase == 0) begin
                    m_if[g].rvalid  = 1'b0;
                    m_if[g].arready = !block_ar && ($urandom_range(0, 3) != 0);
                end else if (phase == 1) begin
                    m_if[g].arready = 1'b0;
                    if (cnt <= 1) begin
                        m_if[g].rvalid = 1'b1;
                        m_if[g].rdata  = resp;
                        phase = 2;
                    end else begin
                        cnt--;
                    end
                end
                #2;
                if (rst_n) begin
                    if (phase == 0 && m_if[g].arvalid && !arv_seen) begin
                        arv_seen = 1'b1;
                        arv_cyc  = cyc;
                    end
                    if (phase == 0 && m_if[g].arvalid && m_if[g].arready) begin
                        phase = 1; cnt = lat; arv_seen = 1'b0;
                        last_araddr = m_if[g].araddr;
                        resp = slave_data(g, m_if[g].araddr);
                        ar_count++;
                    end else if (phase == 2 && m_if[g].rready) begin
                        phase = 0;
                        r_count++;
                    end
                end
            end
        end

        initial begin : wr_model
            bit have_aw;
            bit have_w;
            bit b_done;
            int wait_b;
            have_aw = 1'b0; have_w = 1'b0; b_done = 1'b0; wait_b = 0;
            m_if[g].awready = 1'b0;
            m_if[g].wready  = 1'b0;
            m_if[g].bvalid  = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    have_aw = 1'b0; have_w = 1'b0; b_done = 1'b0;
                    m_if[g].awready = 1'b0;
                    m_if[g].wready  = 1'b0;
                    m_if[g].bvalid  = 1'b0;
                end else begin
                    if (b_done) begin
                        have_aw = 1'b0; have_w = 1'b0; b_done = 1'b0;
                        m_if[g].bvalid = 1'b0;
                    end
                    m_if[g].awready = !have_aw && ($urandom_range(0, 2) != 0);
                    m_if[g].wready  = !have_w  && ($urandom_range(0, 2) != 0);
                    if (have_aw && have_w && !m_if[g].bvalid) begin
                        if (wait_b <= 0) m_if[g].bvalid = 1'b1;
                        else wait_b--;
                    end
                end
                #2;
                if (rst_n) begin
                    if (m_if[g].awvalid && m_if[g].awready) begin
                        have_aw = 1'b1; aw_count++;
                        last_awaddr = m_if[g].awaddr;
                        wait_b = int'($urandom_range(0, 3));
                    end
                    if (m_if[g].wvalid && m_if[g].wready) begin
                        have_w = 1'b1; w_count++;
                        last_wdata = m_if[g].wdata;
                        last_wstrb = m_if[g].wstrb;
                    end
                    if (m_if[g].bvalid && m_if[g].bready) begin
                        b_done = 1'b1; b_count++;
                    end
                end
            end
        end
    end

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output bit ok,
                           output int acc_cyc);
        int n;
        ok = 1'b0; data = '0; acc_cyc = -1; n = 0;
        @(negedge clk);
        s_if.araddr = addr; s_if.arvalid = 1'b1; s_if.rready = 1'b0;
        forever begin
            #2;
            if (s_if.arready) begin acc_cyc = cyc; break; end
            if (++n > 50) break;
            @(negedge clk);
        end
        @(negedge clk);
        s_if.arvalid = 1'b0;
        if (acc_cyc < 0) return;
        s_if.rready = 1'b1; n = 0;
        forever begin
            #2;
            if (s_if.rvalid) begin data = s_if.rdata; ok = 1'b1; break; end
            if (++n > 200) break;
            @(negedge clk);
        end
        @(negedge clk);
        s_if.rready = 1'b0;
    endtask

    // w_lead > 0: W issued that many cycles before AW; < 0: AW first.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, output bit ok, output int early_b);
        int aw_start, w_start, t, n;
        bit aw_done, w_done;
        int es;
        es = exp_slave(addr);
        ok = 1'b0; early_b = 0; t = 0; n = 0; aw_done = 1'b0; w_done = 1'b0;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        while (!(aw_done && w_done) && t < 100) begin
            @(negedge clk);
            s_if.awaddr  = addr;
            s_if.awvalid = !aw_done && (t >= aw_start);
            s_if.wdata   = data;
            s_if.wstrb   = strb;
            s_if.wvalid  = !w_done && (t >= w_start);
            #2;
            if (s_if.awvalid && s_if.awready) aw_done = 1'b1;
            if (s_if.wvalid && s_if.wready) w_done = 1'b1;
            t++;
        end
        @(negedge clk);
        s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
        if (!(aw_done && w_done)) return;
        s_if.bready = 1'b1;
        forever begin
            #2;
            if (s_if.bvalid && !((es == 1) ? m_if[1].bvalid : m_if[0].bvalid)) early_b++;
            if (s_if.bvalid) begin ok = 1'b1; break; end
            if (++n > 200) break;
            @(negedge clk);
        end
        @(negedge clk);
        s_if.bready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        chk++;
        if ({s_if.arready, s_if.awready, s_if.wready} !== 3'b111) begin
            err++; $display("[TB] FAIL reset_readies got %b exp 111", {s_if.arready, s_if.awready, s_if.wready});
        end
        chk++;
        if ({s_if.rvalid, s_if.bvalid} !== 2'b00) begin
            err++; $display("[TB] FAIL reset_s_valids got %b exp 00", {s_if.rvalid, s_if.bvalid});
        end
        chk++;
        if ({m_if[0].arvalid, m_if[0].awvalid, m_if[0].wvalid, m_if[1].arvalid, m_if[1].awvalid,
             m_if[1].wvalid} !== 6'b0) begin
            err++; $display("[TB] FAIL reset_m_valids got nonzero exp 0");
        end
        chk++;
        if ((m_if[0].araddr | m_if[1].araddr | m_if[0].awaddr | m_if[1].awaddr) !== 32'h0) begin
            err++; $display("[TB] FAIL reset_m_addr got nonzero exp 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_s0();
        logic [31:0] d; bit ok; int acc; int a0, a1;
        slv[0].lat = 10;
        a0 = slv[0].ar_count; a1 = slv[1].ar_count;
        do_read(32'h0000_0100, d, ok, acc);
        slv[0].lat = 2;
        chk++;
        if (!ok || d !== 32'hDEAD_BEEF) begin
            err++; $display("[TB] FAIL rd_s0_data got %h ok=%0d exp deadbeef", d, ok);
        end
        chk++;
        if (slv[0].ar_count - a0 !== 1 || slv[1].ar_count - a1 !== 0) begin
            err++; $display("[TB] FAIL rd_s0_route got m0=%0d m1=%0d exp 1/0",
                            slv[0].ar_count - a0, slv[1].ar_count - a1);
        end
        chk++;
        if (slv[0].arv_cyc !== acc + 1) begin
            err++; $display("[TB] FAIL rd_s0_latency got %0d exp %0d", slv[0].arv_cyc, acc + 1);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] addrs [4];
        int          tgt [4];
        logic [31:0] d; bit ok; int acc; int a0, a1, es;
        addrs = '{32'h0FFF_FFFC, 32'h1000_0000, 32'h1FFF_FFFC, 32'h2000_0000};
        tgt   = '{0, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            es = tgt[i];
            a0 = slv[0].ar_count; a1 = slv[1].ar_count;
            do_read(addrs[i], d, ok, acc);
            chk++;
            if (!ok || d !== slave_data(es, addrs[i])) begin
                err++; $display("[TB] FAIL bnd_data addr=%h got %h exp %h", addrs[i], d, slave_data(es, addrs[i]));
            end
            chk++;
            if ((slv[0].ar_count - a0) !== (es == 0 ? 1 : 0) || (slv[1].ar_count - a1) !== es) begin
                err++; $display("[TB] FAIL bnd_route addr=%h got m0=%0d m1=%0d exp slave %0d",
                                addrs[i], slv[0].ar_count - a0, slv[1].ar_count - a1, es);
            end
        end
    endtask

    task automatic test_write_order();
        bit ok; int early; int aw0, aw1, w1, b1;
        aw0 = slv[0].aw_count + slv[0].w_count; aw1 = slv[1].aw_count; w1 = slv[1].w_count; b1 = slv[1].b_count;
        do_write(32'h1000_0010, 32'h1234_5678, 4'hF, 3, ok, early);
        chk++;
        if (!ok || early !== 0) begin
            err++; $display("[TB] FAIL wr_order_resp got ok=%0d early=%0d exp 1/0", ok, early);
        end
        chk++;
        if (slv[1].aw_count - aw1 !== 1 || slv[1].w_count - w1 !== 1 || slv[1].b_count - b1 !== 1 ||
            slv[0].aw_count + slv[0].w_count !== aw0) begin
            err++; $display("[TB] FAIL wr_order_count got aw=%0d w=%0d b=%0d exp 1/1/1",
                            slv[1].aw_count - aw1, slv[1].w_count - w1, slv[1].b_count - b1);
        end
        chk++;
        if (slv[1].last_awaddr !== 32'h1000_0010 || slv[1].last_wdata !== 32'h1234_5678 ||
            slv[1].last_wstrb !== 4'hF) begin
            err++; $display("[TB] FAIL wr_order_payload got %h/%h/%h exp 10000010/12345678/f",
                            slv[1].last_awaddr, slv[1].last_wdata, slv[1].last_wstrb);
        end
    endtask

    task automatic test_concurrent();
        logic [31:0] d; bit rok, wok; int acc, early;
        int ar0, ar1, aw0, aw1;
        logic [31:0] wd;
        wd = $urandom();
        ar0 = slv[0].ar_count; ar1 = slv[1].ar_count; aw0 = slv[0].aw_count; aw1 = slv[1].aw_count;
        fork
            do_read(32'h0000_0100, d, rok, acc);
            do_write(32'h1000_0004, wd, 4'h5, 0, wok, early);
        join
        chk++;
        if (!rok || d !== 32'hDEAD_BEEF) begin
            err++; $display("[TB] FAIL conc_read got %h ok=%0d exp deadbeef", d, rok);
        end
        chk++;
        if (!wok || slv[1].last_wdata !== wd || slv[1].last_awaddr !== 32'h1000_0004) begin
            err++; $display("[TB] FAIL conc_write got %h@%h ok=%0d exp %h@10000004",
                            slv[1].last_wdata, slv[1].last_awaddr, wok, wd);
        end
        chk++;
        if (slv[0].ar_count - ar0 !== 1 || slv[1].ar_count - ar1 !== 0 ||
            slv[0].aw_count - aw0 !== 0 || slv[1].aw_count - aw1 !== 1) begin
            err++; $display("[TB] FAIL conc_isolation got ar=%0d/%0d aw=%0d/%0d exp 1/0 0/1",
                            slv[0].ar_count - ar0, slv[1].ar_count - ar1,
                            slv[0].aw_count - aw0, slv[1].aw_count - aw1);
        end
    endtask

    task automatic test_backpressure();
        int n;
        bit seen;
        @(negedge clk);
        s_if.araddr = 32'h0000_0100; s_if.arvalid = 1'b1; s_if.rready = 1'b0;
        #2;
        @(negedge clk);
        s_if.arvalid = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            #2;
            seen = s_if.rvalid;
            n++;
        end
        chk++;
        if (!seen) begin
            err++; $display("[TB] FAIL bp_rvalid_timeout got 0 exp 1");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            chk++;
            if (s_if.rvalid !== 1'b1 || s_if.rdata !== 32'hDEAD_BEEF || s_if.arready !== 1'b0) begin
                err++; $display("[TB] FAIL bp_hold cyc%0d got rv=%b d=%h arr=%b exp 1/deadbeef/0",
                                i, s_if.rvalid, s_if.rdata, s_if.arready);
            end
        end
        @(negedge clk);
        s_if.rready = 1'b1;
        @(negedge clk);
        s_if.rready = 1'b0;
        #2;
        chk++;
        if (s_if.arready !== 1'b1 || s_if.rvalid !== 1'b0) begin
            err++; $display("[TB] FAIL bp_release got arr=%b rv=%b exp 1/0", s_if.arready, s_if.rvalid);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d; bit ok; int acc;
        slv[0].block_ar = 1'b1;
        @(negedge clk);
        s_if.araddr = 32'h0000_0200; s_if.arvalid = 1'b1;
        @(negedge clk);
        s_if.arvalid = 1'b0;
        @(negedge clk);
        #2;
        chk++;
        if (m_if[0].arvalid !== 1'b1) begin
            err++; $display("[TB] FAIL rst_mid_pending got m0_arvalid=%b exp 1", m_if[0].arvalid);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        chk++;
        if ({m_if[0].arvalid, m_if[1].arvalid, s_if.rvalid, s_if.bvalid} !== 4'b0 || s_if.arready !== 1'b1) begin
            err++; $display("[TB] FAIL rst_mid_state got valids=%b arr=%b exp 0000/1",
                            {m_if[0].arvalid, m_if[1].arvalid, s_if.rvalid, s_if.bvalid}, s_if.arready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        slv[0].block_ar = 1'b0;
        do_read(32'h0000_0300, d, ok, acc);
        chk++;
        if (!ok || d !== slave_data(0, 32'h0000_0300)) begin
            err++; $display("[TB] FAIL rst_mid_recover got %h ok=%0d exp %h", d, ok, slave_data(0, 32'h0000_0300));
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, d, wd; logic [3:0] st;
        bit ok; int acc, early, es, lead;
        int c0, c1;
        for (int i = 0; i < 30; i++) begin
            addr = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1) addr[31:28] = 4'h1;
            es = exp_slave(addr);
            if ($urandom_range(0, 1) == 0) begin
                c0 = slv[0].ar_count; c1 = slv[1].ar_count;
                do_read(addr, d, ok, acc);
                chk++;
                if (!ok || d !== slave_data(es, addr) ||
                    (slv[0].ar_count - c0) !== (es == 0 ? 1 : 0) || (slv[1].ar_count - c1) !== es) begin
                    err++; $display("[TB] FAIL rand_read addr=%h got %h exp %h from slave %0d",
                                    addr, d, slave_data(es, addr), es);
                end
            end else begin
                wd = $urandom(); st = 4'($urandom_range(1, 15)); lead = int'($urandom_range(0, 6)) - 3;
                c0 = slv[0].aw_count; c1 = slv[1].aw_count;
                do_write(addr, wd, st, lead, ok, early);
                chk++;
                if (!ok || early !== 0 ||
                    (slv[0].aw_count - c0) !== (es == 0 ? 1 : 0) || (slv[1].aw_count - c1) !== es ||
                    (es == 1 ? slv[1].last_awaddr : slv[0].last_awaddr) !== addr ||
                    (es == 1 ? slv[1].last_wdata : slv[0].last_wdata) !== wd ||
                    (es == 1 ? slv[1].last_wstrb : slv[0].last_wstrb) !== st) begin
                    err++; $display("[TB] FAIL rand_write addr=%h ok=%0d early=%0d exp slave %0d data %h strb %h",
                                    addr, ok, early, es, wd, st);
                end
            end
        end
    endtask

    initial begin
        s_if.araddr = '0; s_if.arvalid = 1'b0; s_if.rready = 1'b0;
        s_if.awaddr = '0; s_if.awvalid = 1'b0;
        s_if.wdata = '0; s_if.wstrb = '0; s_if.wvalid = 1'b0; s_if.bready = 1'b0;
        test_reset();
        test_read_s0();
        test_boundaries();
        test_write_order();
        test_concurrent();
        test_backpressure();
        test_reset_mid_read();
        test_random();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule
